// File: rtl/fight_pkg.sv
// Shared constants and the damage lookup used by the two-player skill arbiter.
package fight_pkg;

    localparam logic [2:0] SK_TELEPORT = 3'd0;
    localparam logic [2:0] SK_HEAVY    = 3'd7;

    localparam logic PLAYER_1 = 1'b0;
    localparam logic PLAYER_2 = 1'b1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GRANT   = 3'd1;
    localparam logic [2:0] ST_ANIM    = 3'd2;
    localparam logic [2:0] ST_RESOLVE = 3'd3;
    localparam logic [2:0] ST_OVER    = 3'd4;

    function automatic logic [2:0] skill_damage(input logic [2:0] skill);
        if (skill == SK_TELEPORT) begin
            return 3'd0;
        end else if (skill == SK_HEAVY) begin
            return 3'd6;
        end
        return 3'd1 + {1'b0, skill[2:1]};
    endfunction

endpackage

// File: rtl/skill_arbiter_if.sv
// Request/status bundle between the combo decoders and the arbiter.
// Drop counters exist only when DROP_STATS_EN is defined.
interface skill_arbiter_if #(
    parameter int unsigned HP_W = 5
);
    logic            p1_req;
    logic [2:0]      p1_skill;
    logic            p2_req;
    logic [2:0]      p2_skill;
    logic            anim_start;
    logic            anim_player;
    logic [2:0]      anim_skill;
    logic [HP_W-1:0] p1_hp;
    logic [HP_W-1:0] p2_hp;
    logic            p1_ready;
    logic            p2_ready;
    logic            game_over;
    logic            winner;
`ifdef DROP_STATS_EN
    logic [7:0]      p1_drops;
    logic [7:0]      p2_drops;
`endif

    modport master (
        output p1_req, p1_skill, p2_req, p2_skill,
`ifdef DROP_STATS_EN
        input  p1_drops, p2_drops,
`endif
        input  anim_start, anim_player, anim_skill, p1_hp, p2_hp,
        input  p1_ready, p2_ready, game_over, winner
    );

    modport slave (
        input  p1_req, p1_skill, p2_req, p2_skill,
`ifdef DROP_STATS_EN
        output p1_drops, p2_drops,
`endif
        output anim_start, anim_player, anim_skill, p1_hp, p2_hp,
        output p1_ready, p2_ready, game_over, winner
    );

endinterface

// File: rtl/skill_req_latch.sv
// Per-player request holder: pending flag, stored skill, cooldown and ready.
// DROP_STATS_EN adds a saturating count of requests dropped while not ready.
module skill_req_latch #(
    parameter int unsigned CD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [2:0] skill,
    input  logic       grant,
    input  logic       resolve_self,
    input  logic       over,
    output logic       pending,
    output logic [2:0] stored_skill,
    output logic       ready
`ifdef DROP_STATS_EN
    ,
    output logic [7:0] drops
`endif
);

    localparam int unsigned CD_W = $clog2(CD_CYCLES + 1);

    logic            pending_q;
    logic [2:0]      skill_q;
    logic [CD_W-1:0] cd_q;
    logic            accept;

    assign ready  = !pending_q && (cd_q == '0) && !over;
    // The resolve cycle loads the cooldown, so a request landing on it is lost.
    assign accept = req && ready && !resolve_self;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= 1'b0;
            skill_q   <= 3'd0;
            cd_q      <= '0;
        end else begin
            if (accept) begin
                pending_q <= 1'b1;
                skill_q   <= skill;
            end else if (grant) begin
                pending_q <= 1'b0;
            end
            if (resolve_self) begin
                cd_q <= CD_W'(CD_CYCLES);
            end else if (cd_q != '0) begin
                cd_q <= cd_q - CD_W'(1);
            end
        end
    end

    assign pending      = pending_q;
    assign stored_skill = skill_q;

`ifdef DROP_STATS_EN
    logic [7:0] drops_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drops_q <= 8'd0;
        end else if (req && !accept && !over && (drops_q != 8'hff)) begin
            drops_q <= drops_q + 8'd1;
        end
    end

    assign drops = drops_q;
`endif

endmodule

// File: rtl/skill_arbiter.sv
// Round-robin arbiter granting the shared animation engine to one player,
// resolving damage and declaring game over. Optional macro: DROP_STATS_EN.
module skill_arbiter
    import fight_pkg::*;
#(
    parameter int unsigned HP_W        = 5,
    parameter int unsigned HP_INIT     = 20,
    parameter int unsigned ANIM_CYCLES = 4,
    parameter int unsigned CD_CYCLES   = 8
) (
    input  logic           clk,
    input  logic           reset,
    skill_arbiter_if.slave bus
);

    localparam int unsigned AC_W = (ANIM_CYCLES > 1) ? $clog2(ANIM_CYCLES) : 1;
    localparam logic [HP_W-1:0] HP_START = HP_W'(HP_INIT);

    logic [2:0]      state_q, state_d;
    logic [AC_W-1:0] cnt_q, cnt_d;
    logic            player_q, player_d;
    logic [2:0]      skill_q, skill_d;
    logic            rr_q, rr_d;
    logic [HP_W-1:0] p1_hp_q, p1_hp_d, p2_hp_q, p2_hp_d;
    logic            p1_dodge_q, p1_dodge_d, p2_dodge_q, p2_dodge_d;
    logic            winner_q, winner_d;

    logic            p1_pending, p2_pending;
    logic [2:0]      p1_stored, p2_stored;
    logic            over, p1_grant, p2_grant, p1_resolve, p2_resolve;
    logic            pick_p2, victim_dodge;
    logic [2:0]      dmg;
    logic [HP_W-1:0] victim_hp, new_hp;

    assign over       = (state_q == ST_OVER);
    assign p1_grant   = (state_q == ST_GRANT) && (player_q == PLAYER_1);
    assign p2_grant   = (state_q == ST_GRANT) && (player_q == PLAYER_2);
    assign p1_resolve = (state_q == ST_RESOLVE) && (player_q == PLAYER_1);
    assign p2_resolve = (state_q == ST_RESOLVE) && (player_q == PLAYER_2);

    skill_req_latch #(.CD_CYCLES(CD_CYCLES)) u_p1_latch (
        .clk          (clk),
        .reset        (reset),
        .req          (bus.p1_req),
        .skill        (bus.p1_skill),
        .grant        (p1_grant),
        .resolve_self (p1_resolve),
        .over         (over),
        .pending      (p1_pending),
        .stored_skill (p1_stored),
        .ready        (bus.p1_ready)
`ifdef DROP_STATS_EN
        ,
        .drops        (bus.p1_drops)
`endif
    );

    skill_req_latch #(.CD_CYCLES(CD_CYCLES)) u_p2_latch (
        .clk          (clk),
        .reset        (reset),
        .req          (bus.p2_req),
        .skill        (bus.p2_skill),
        .grant        (p2_grant),
        .resolve_self (p2_resolve),
        .over         (over),
        .pending      (p2_pending),
        .stored_skill (p2_stored),
        .ready        (bus.p2_ready)
`ifdef DROP_STATS_EN
        ,
        .drops        (bus.p2_drops)
`endif
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        player_d     = player_q;
        skill_d      = skill_q;
        rr_d         = rr_q;
        p1_hp_d      = p1_hp_q;
        p2_hp_d      = p2_hp_q;
        p1_dodge_d   = p1_dodge_q;
        p2_dodge_d   = p2_dodge_q;
        winner_d     = winner_q;
        pick_p2      = 1'b0;
        victim_dodge = 1'b0;
        dmg          = 3'd0;
        victim_hp    = '0;
        new_hp       = '0;
        case (state_q)
            ST_IDLE: begin
                if (p1_pending || p2_pending) begin
                    pick_p2  = p2_pending && (!p1_pending || (rr_q == PLAYER_2));
                    player_d = pick_p2 ? PLAYER_2 : PLAYER_1;
                    skill_d  = pick_p2 ? p2_stored : p1_stored;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                rr_d    = ~player_q;
                cnt_d   = AC_W'(ANIM_CYCLES - 1);
                state_d = (ANIM_CYCLES == 1) ? ST_RESOLVE : ST_ANIM;
            end
            ST_ANIM: begin
                // Leave when the counter reaches zero so GRANT..RESOLVE spans ANIM_CYCLES.
                cnt_d = cnt_q - AC_W'(1);
                if (cnt_q <= AC_W'(1)) begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                victim_hp    = (player_q == PLAYER_1) ? p2_hp_q : p1_hp_q;
                victim_dodge = (player_q == PLAYER_1) ? p2_dodge_q : p1_dodge_q;
                dmg          = victim_dodge ? 3'd0 : skill_damage(skill_q);
                new_hp       = (victim_hp > HP_W'(dmg)) ? victim_hp - HP_W'(dmg) : '0;
                if (player_q == PLAYER_1) begin
                    p2_hp_d    = new_hp;
                    p2_dodge_d = 1'b0;
                    if (skill_q == SK_TELEPORT) p1_dodge_d = 1'b1;
                end else begin
                    p1_hp_d    = new_hp;
                    p1_dodge_d = 1'b0;
                    if (skill_q == SK_TELEPORT) p2_dodge_d = 1'b1;
                end
                if (new_hp == '0) begin
                    state_d  = ST_OVER;
                    winner_d = player_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OVER: state_d = ST_OVER;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            player_q   <= PLAYER_1;
            skill_q    <= 3'd0;
            rr_q       <= PLAYER_1;
            p1_hp_q    <= HP_START;
            p2_hp_q    <= HP_START;
            p1_dodge_q <= 1'b0;
            p2_dodge_q <= 1'b0;
            winner_q   <= PLAYER_1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            player_q   <= player_d;
            skill_q    <= skill_d;
            rr_q       <= rr_d;
            p1_hp_q    <= p1_hp_d;
            p2_hp_q    <= p2_hp_d;
            p1_dodge_q <= p1_dodge_d;
            p2_dodge_q <= p2_dodge_d;
            winner_q   <= winner_d;
        end
    end

    assign bus.anim_start  = (state_q == ST_GRANT);
    assign bus.anim_player = player_q;
    assign bus.anim_skill  = skill_q;
    assign bus.p1_hp       = p1_hp_q;
    assign bus.p2_hp       = p2_hp_q;
    assign bus.game_over   = over;
    assign bus.winner      = winner_q;

endmodule

// File: tb/tb_skill_arbiter.sv
// Directed bench for skill_arbiter: cycle tables for the basic and simultaneous
// cases, then hand-written sequences for dodge, game over, reset and drop stats.
module tb_skill_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    skill_arbiter_if #(.HP_W(5)) bus ();

    skill_arbiter #(
        .HP_W        (5),
        .HP_INIT     (20),
        .ANIM_CYCLES (4),
        .CD_CYCLES   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    typedef struct {
        logic       rst;
        logic       r1;
        logic [2:0] s1;
        logic       r2;
        logic [2:0] s2;
        logic       e_start;
        logic       chk;
        logic       e_pl;
        logic [2:0] e_sk;
        logic [4:0] e_hp1;
        logic [4:0] e_hp2;
        logic       e_rd1;
        logic       e_rd2;
        logic       e_over;
    } vec_t;

    vec_t vq[$];

    task automatic row(input int rst, input int r1, input int s1, input int r2, input int s2,
                       input int st, input int chk, input int pl, input int sk,
                       input int hp1, input int hp2, input int rd1, input int rd2,
                       input int ov);
        vec_t v;
        v.rst = 1'(rst);  v.r1 = 1'(r1);  v.s1 = 3'(s1);  v.r2 = 1'(r2);  v.s2 = 3'(s2);
        v.e_start = 1'(st);  v.chk = 1'(chk);  v.e_pl = 1'(pl);  v.e_sk = 3'(sk);
        v.e_hp1 = 5'(hp1);  v.e_hp2 = 5'(hp2);
        v.e_rd1 = 1'(rd1);  v.e_rd2 = 1'(rd2);  v.e_over = 1'(ov);
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.p1_req = 1'b0;
        bus.p2_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Called at a negedge; holds the request for exactly one sampling edge.
    task automatic issue(input logic pl, input logic [2:0] sk);
        if (pl) begin
            bus.p2_req   = 1'b1;
            bus.p2_skill = sk;
        end else begin
            bus.p1_req   = 1'b1;
            bus.p1_skill = sk;
        end
        @(negedge clk);
        bus.p1_req = 1'b0;
        bus.p2_req = 1'b0;
    endtask

    task automatic wait_start(input logic pl, input logic [2:0] sk, input string name);
        int n = 0;
        while (bus.anim_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, ".start"}, 32'(bus.anim_start), 32'd1);
        check({name, ".player"}, 32'(bus.anim_player), 32'(pl));
        check({name, ".skill"}, 32'(bus.anim_skill), 32'(sk));
    endtask

    task automatic wait_ready(input logic pl, input string name);
        int n = 0;
        while ((pl ? bus.p2_ready : bus.p1_ready) !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, ".ready"}, 32'(pl ? bus.p2_ready : bus.p1_ready), 32'd1);
    endtask

    initial begin
        logic [14:0] act;
        logic [14:0] exp;
        int          exp_hp;
        logic        seen;

        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        bus.p1_req   = 1'b0;
        bus.p1_skill = 3'd0;
        bus.p2_req   = 1'b0;
        bus.p2_skill = 3'd0;

        // Single heavy punch from P1; requests on its RESOLVE and in cooldown are dropped.
        //  rst r1 s1 r2 s2  st chk pl sk  hp1 hp2  rd1 rd2 ov
        row(1, 1, 7, 0, 0,  0, 0, 0, 0,  20, 20,  1, 1, 0);
        row(0, 0, 0, 0, 0,  0, 0, 0, 0,  20, 20,  0, 1, 0);
        row(0, 0, 0, 0, 0,  1, 1, 0, 7,  20, 20,  0, 1, 0);
        row(0, 0, 0, 0, 0,  0, 1, 0, 7,  20, 20,  1, 1, 0);
        row(0, 0, 0, 0, 0,  0, 1, 0, 7,  20, 20,  1, 1, 0);
        row(0, 0, 0, 0, 0,  0, 1, 0, 7,  20, 20,  1, 1, 0);
        row(0, 1, 3, 0, 0,  0, 1, 0, 7,  20, 20,  1, 1, 0);
        for (int c = 7; c <= 14; c++) begin
            row(0, (c == 10) ? 1 : 0, 1, 0, 0,  0, 0, 0, 0,  20, 14,  0, 1, 0);
        end
        row(0, 0, 0, 0, 0,  0, 0, 0, 0,  20, 14,  1, 1, 0);

        // Simultaneous requests: P1 first by round-robin, P2 two cycles after P1 resolves.
        row(1, 1, 1, 1, 3,  0, 0, 0, 0,  20, 20,  1, 1, 0);
        row(0, 0, 0, 0, 0,  0, 0, 0, 0,  20, 20,  0, 0, 0);
        row(0, 0, 0, 0, 0,  1, 1, 0, 1,  20, 20,  0, 0, 0);
        for (int c = 3; c <= 6; c++) row(0, 0, 0, 0, 0,  0, 1, 0, 1,  20, 20,  1, 0, 0);
        row(0, 0, 0, 0, 0,  0, 0, 0, 0,  20, 19,  0, 0, 0);
        row(0, 0, 0, 0, 0,  1, 1, 1, 3,  20, 19,  0, 0, 0);
        for (int c = 9; c <= 12; c++) row(0, 0, 0, 0, 0,  0, 1, 1, 3,  20, 19,  0, 1, 0);
        row(0, 0, 0, 0, 0,  0, 0, 0, 0,  18, 19,  0, 0, 0);
        row(0, 0, 0, 0, 0,  0, 0, 0, 0,  18, 19,  0, 0, 0);
        row(0, 0, 0, 0, 0,  0, 0, 0, 0,  18, 19,  1, 0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            if (vq[i].rst) begin
                reset = 1'b0;
                #1;
                reset = 1'b1;
                #1;
            end
            act = {bus.anim_start, bus.p1_hp, bus.p2_hp, bus.p1_ready, bus.p2_ready,
                   bus.game_over};
            exp = {vq[i].e_start, vq[i].e_hp1, vq[i].e_hp2, vq[i].e_rd1, vq[i].e_rd2,
                   vq[i].e_over};
            check($sformatf("vec[%0d].status", i), 32'(act), 32'(exp));
            if (vq[i].chk) begin
                check($sformatf("vec[%0d].anim", i), 32'({bus.anim_player, bus.anim_skill}),
                      32'({vq[i].e_pl, vq[i].e_sk}));
            end
            bus.p1_req   = vq[i].r1;
            bus.p1_skill = vq[i].s1;
            bus.p2_req   = vq[i].r2;
            bus.p2_skill = vq[i].s2;
        end

        // Teleport dodge absorbs exactly one hit.
        do_reset();
        issue(1'b1, 3'd0);
        wait_start(1'b1, 3'd0, "tele");
        repeat (5) @(negedge clk);
        check("tele.p1_hp", 32'(bus.p1_hp), 32'd20);
        issue(1'b0, 3'd7);
        wait_start(1'b0, 3'd7, "dodged");
        repeat (5) @(negedge clk);
        check("dodged.p2_hp", 32'(bus.p2_hp), 32'd20);
        wait_ready(1'b0, "dodged");
        issue(1'b0, 3'd7);
        wait_start(1'b0, 3'd7, "after_dodge");
        repeat (5) @(negedge clk);
        check("after_dodge.p2_hp", 32'(bus.p2_hp), 32'd14);

        // Repeated heavy punches saturate P2 at zero and end the game.
        do_reset();
        exp_hp = 20;
        for (int k = 0; k < 4; k++) begin
            wait_ready(1'b0, $sformatf("ko%0d", k));
            issue(1'b0, 3'd7);
            wait_start(1'b0, 3'd7, $sformatf("ko%0d", k));
            repeat (5) @(negedge clk);
            exp_hp = (exp_hp > 6) ? exp_hp - 6 : 0;
            check($sformatf("ko%0d.p2_hp", k), 32'(bus.p2_hp), 32'(exp_hp));
        end
        check("ko.game_over", 32'(bus.game_over), 32'd1);
        check("ko.winner", 32'(bus.winner), 32'd0);
        check("ko.ready", 32'({bus.p1_ready, bus.p2_ready}), 32'd0);
        issue(1'b1, 3'd7);
        issue(1'b0, 3'd6);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.anim_start) seen = 1'b1;
        end
        check("over.no_start", 32'(seen), 32'd0);
        check("over.hp", 32'({bus.p1_hp, bus.p2_hp}), 32'({5'd20, 5'd0}));
        check("over.game_over", 32'(bus.game_over), 32'd1);

        // Asynchronous reset in the middle of an animation.
        do_reset();
        issue(1'b1, 3'd7);
        wait_start(1'b1, 3'd7, "pre_rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst.anim", 32'({bus.anim_start, bus.anim_player, bus.anim_skill}), 32'd0);
        check("mid_rst.hp", 32'({bus.p1_hp, bus.p2_hp}), 32'({5'd20, 5'd20}));
        check("mid_rst.flags", 32'({bus.p1_ready, bus.p2_ready, bus.game_over, bus.winner}),
              32'b1100);
        @(negedge clk);
        reset = 1'b1;
        issue(1'b0, 3'd5);
        wait_start(1'b0, 3'd5, "post_rst");
        repeat (5) @(negedge clk);
        check("post_rst.hp", 32'({bus.p1_hp, bus.p2_hp}), 32'({5'd20, 5'd17}));

`ifdef DROP_STATS_EN
        do_reset();
        issue(1'b0, 3'd7);
        wait_start(1'b0, 3'd7, "drops");
        repeat (5) @(negedge clk);
        seen = 1'b0;
        repeat (3) begin
            issue(1'b0, 3'd2);
            if (bus.anim_start) seen = 1'b1;
            @(negedge clk);
            if (bus.anim_start) seen = 1'b1;
        end
        check("drops.p1", 32'(bus.p1_drops), 32'd3);
        check("drops.p2", 32'(bus.p2_drops), 32'd0);
        check("drops.no_start", 32'(seen), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/skill_arbiter.md
Name: skill_arbiter

Overview:
Two-player arbiter/scheduler between the per-player combo decoders and the shared hit-resolution/animation path. It latches skill requests (3-bit skill codes) from both players and grants the shared animation engine to one player at a time, using round-robin priority. After each animation it resolves damage against the opponent's HP and enforces a per-player cooldown. It declares game over when an HP reaches zero.

Parameters:
HP_W, 5, width of HP counters
HP_INIT, 20, HP loaded into both players at reset
ANIM_CYCLES, 4, cycles the shared animation engine is held per granted skill (>=1)
CD_CYCLES, 8, cooldown cycles after a player's skill resolves (>=1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
p1_req  input  1  single-cycle request pulse from player-1 decoder
p1_skill  input  3  skill code, valid with p1_req
p2_req  input  1  single-cycle request pulse from player-2 decoder
p2_skill  input  3  skill code, valid with p2_req
anim_start  output  1  one-cycle pulse: animation engine starts
anim_player  output  1  0 = player 1, 1 = player 2; valid from anim_start until resolve
anim_skill  output  3  granted skill code; same validity as anim_player
p1_hp  output  HP_W  player-1 HP
p2_hp  output  HP_W  player-2 HP
p1_ready  output  1  player 1 may issue a request (no pending request, not cooling)
p2_ready  output  1  same for player 2
game_over  output  1  high in OVER state
winner  output  1  0 = player 1 won, 1 = player 2 won; valid when game_over

Behaviour:
- Reset (async, active-low), effective immediately:
  - state = IDLE; p1_hp = p2_hp = HP_INIT.
  - anim_start = 0, anim_player = 0, anim_skill = 0, game_over = 0, winner = 0.
  - Pending flags, dodge flags and cooldown counters cleared; RR pointer = player 1; p1_ready = p2_ready = 1.
  - Reset mid-animation or mid-cooldown abandons all work.
- Request latch, per player:
  - A req is accepted only when ready = 1. It sets pending and stores the skill. ready falls the next cycle.
  - A req arriving while not ready is dropped silently.
- Cooldown: loaded with CD_CYCLES on the RESOLVE cycle of that player's skill. Decrements each cycle. ready = !pending && cd == 0.
- FSM states: IDLE, GRANT, ANIM, RESOLVE, OVER.
  - IDLE: if any pending, go to GRANT. If both are pending, the RR pointer's player wins.
  - GRANT (1 cycle):
    - anim_start = 1; anim_player/anim_skill load the winner.
    - The winner's pending clears; the RR pointer flips to the other player.
    - Load the anim counter with ANIM_CYCLES-1; go to ANIM.
  - ANIM: decrement the counter; at 0 go to RESOLVE. Total GRANT to RESOLVE = ANIM_CYCLES cycles.
  - RESOLVE (1 cycle): apply the damage table to the opponent, load the attacker's cooldown, then:
    - go to OVER if the opponent's HP becomes 0;
    - else go to IDLE. Requests pending at that point are granted from IDLE one cycle later.
- Damage table:
  - skill 0 (teleport) = 0 damage; sets the attacker's dodge flag.
  - skills 1..6 = 1 + skill[2:1]; skill 7 (heavy punch) = 6.
  - If the victim's dodge flag is set, damage = 0 and that dodge flag clears.
  - A second teleport while dodge is already set has no extra effect.
- HP arithmetic: saturating subtract, never below 0, width HP_W.
- OVER:
  - game_over = 1; winner = attacker of the final resolve.
  - All requests dropped; ready = 0 for both players; HP frozen.
  - Exit only via reset.
- Simultaneous events:
  - Requests from both players in the same cycle are both latched.
  - A req on the same cycle as that player's RESOLVE is dropped, because cooldown starts.

Optional Feature:
Macro DROP_STATS_EN.
- Defined: adds outputs p1_drops and p2_drops (8-bit each).
  - Each counts requests dropped while not ready; saturates at 255; cleared by reset.
  - Drops during OVER are not counted.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fight_pkg:
  - skill code constants (SK_TELEPORT = 3'd0, SK_HEAVY = 3'd7);
  - FSM state enum;
  - damage lookup function (skill -> 3-bit damage);
  - player index constants.
- Sub-module skill_req_latch, instantiated per player:
  - contains the pending flag, stored skill, cooldown counter, ready and the optional drop counter;
  - inputs: req, skill, grant, resolve_self, over.

Test Plan:
- Reset, then p1_req with skill 7 -> anim_start pulse, anim_player = 0, anim_skill = 7; after 4 cycles p2_hp = 14, p1_ready low for 8 cycles after resolve.
- p1_req (skill 1) and p2_req (skill 3) in the same cycle after reset -> P1 granted first, P2 granted in the cycle after P1's RESOLVE+1; p2_hp = 19, p1_hp = 18.
- P2 plays skill 0, then P1 plays skill 7 -> p2_hp stays 20, dodge consumed; a second P1 skill 7 after cooldown -> p2_hp = 14.
- P1 issues repeated skill 7s (4 resolves, 24 damage) -> p2_hp saturates to 0 (not wrap), game_over = 1, winner = 0; later requests ignored; HP frozen.
- Assert reset mid-ANIM -> all outputs at reset values immediately, HP = 20; a fresh request is granted normally.
- With DROP_STATS_EN: p1_req pulsed 3 times during cooldown -> p1_drops = 3; no grant occurs.
